// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM state encoding
//   NOP_INSTR     : instruction held after reset (addi x0,x0,0)
//   PC_STEP       : sequential PC increment in bytes
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// pc_next_calc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc         in   XLEN  current PC
//   pc_src     in   1     1 = branch target, 0 = sequential
//   imm_ext    in   XLEN  sign-extended branch offset
//   next_pc    out  XLEN  raw candidate PC (wraps mod 2^XLEN)
//   misaligned out  1     candidate PC is not word aligned
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc    = pc_src ? (pc + imm_ext) : (pc + XLEN'(PC_STEP));
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, requests one word at a time
// from instruction memory over a valid/ready handshake, holds the returned word
// for decode, and steps the PC (+4 or branch target) when decode retires it.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   imem_req_valid/ready, imem_addr  request channel (imem_addr == pc)
//   imem_rsp_valid, imem_rsp_data    response channel
//   instr, instr_valid, instr_ack    held instruction towards decode
//   pc_src, imm_ext                  next-PC select, sampled with instr_ack
//   pc, pc_plus4                     PC of held/pending instruction, pc + 4
//   fetch_fault                      misaligned-target trap
// Build option FETCH_MISALIGN_CHECK_EN: when defined, a misaligned retire target
// traps into S_FAULT (left only by reset); when undefined the target's low two
// bits are cleared and fetch_fault is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_REQ   | request word at pc, wait for imem_req_ready
// S_WAIT  | request accepted, wait for imem_rsp_valid
// S_HOLD  | instr valid towards decode, wait for instr_ack
// S_FAULT | misaligned target trapped, idle until reset (option only)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ack,
    input  logic            pc_src,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_fault
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            instr_valid_q;
    logic            req_valid_q;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
        .pc         (pc_q),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state         <= S_HOLD;
                        instr_q       <= imem_rsp_data;
                        instr_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        instr_valid_q <= 1'b0;
                        if (misaligned) begin
                            // pc keeps the faulting instruction's address
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state       <= S_REQ;
                            pc_q        <= next_pc;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    assign fetch_fault = fault_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b1;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state         <= S_HOLD;
                        instr_q       <= imem_rsp_data;
                        instr_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        state         <= S_REQ;
                        instr_valid_q <= 1'b0;
                        req_valid_q   <= 1'b1;
                        // misaligned targets are silently word-aligned
                        pc_q <= misaligned ? {next_pc[XLEN-1:2], 2'b00} : next_pc;
                    end
                end
                default: begin
                    // S_FAULT is unreachable without the check; recover anyway
                    state       <= S_REQ;
                    req_valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_fault = 1'b0;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(PC_STEP);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: drives the imem and decode sides, keeps a
// queue-based reference of expected fetch addresses and held instructions, and
// checks them from an independent monitor. Honours FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imm_ext = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ack      (instr_ack),
        .pc_src         (pc_src),
        .imm_ext        (imm_ext),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        prev_iv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: next PC from the architectural rule, wrapping mod 2^32.
    function automatic logic [31:0] raw_next(input logic [31:0] cur, input logic src,
                                             input logic [31:0] imm);
        return src ? cur + imm : cur + 32'd4;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a request handshake
    // or a newly valid instruction.
    initial begin
        logic [31:0] e;
        logic [31:0] ep;
        prev_iv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_iv = 1'b0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_req: addr %h, none expected", imem_addr);
                    end else begin
                        e = exp_addr_q.pop_front();
                        chk("req_addr", imem_addr, e);
                        chk("pc_plus4", pc_plus4, e + 32'd4);
                    end
                end
                if (instr_valid && !prev_iv) begin
                    if (exp_instr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_instr: instr %h, none expected", instr);
                    end else begin
                        e  = exp_instr_q.pop_front();
                        ep = exp_pc_q.pop_front();
                        chk("held_instr", instr, e);
                        chk("held_pc", pc, ep);
                    end
                end
                prev_iv = instr_valid;
            end
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ack      = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_pc_q.delete();
        m_pc    = 32'h0;
        m_instr = NOP_INSTR;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        rst_n = 1'b1;
        exp_addr_q.push_back(m_pc);
        @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1);
    endtask

    // One full instruction; entered just after a clock edge with DUT in S_REQ.
    // Returns 1 in faulted if the retire trapped (check build only).
    task automatic do_instr(input int req_wait, input int rsp_wait, input int hold_wait,
                            input logic src, input logic [31:0] imm, input logic spurious,
                            output logic faulted);
        logic [31:0] data;
        logic [31:0] nxt;
        faulted = 1'b0;
        chk("in_req", imem_req_valid, 1);
        for (int i = 0; i < req_wait; i++) begin
            imem_rsp_valid = spurious;
            imem_rsp_data  = $urandom;
            @(posedge clk);
            #1;
            chk("req_addr_stable", imem_addr, m_pc);
            chk("req_valid_held", imem_req_valid, 1);
            chk("req_instr_kept", instr, m_instr);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        chk("req_dropped", imem_req_valid, 0);
        data = $urandom;
        exp_instr_q.push_back(data);
        exp_pc_q.push_back(m_pc);
        for (int i = 0; i < rsp_wait; i++) begin
            instr_ack = spurious;
            pc_src    = 1'b1;
            imm_ext   = $urandom;
            @(posedge clk);
            #1;
            chk("wait_not_valid", instr_valid, 0);
            chk("wait_pc", pc, m_pc);
        end
        instr_ack      = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        m_instr = data;
        chk("hold_valid", instr_valid, 1);
        for (int i = 0; i < hold_wait; i++) begin
            imem_rsp_valid = spurious;
            imem_rsp_data  = ~data;
            @(posedge clk);
            #1;
            chk("hold_instr", instr, data);
            chk("hold_pc", pc, m_pc);
        end
        imem_rsp_valid = 1'b0;
        instr_ack = 1'b1;
        pc_src    = src;
        imm_ext   = imm;
        nxt = raw_next(m_pc, src, imm);
`ifdef FETCH_MISALIGN_CHECK_EN
        if (nxt[1:0] != 2'b00) begin
            @(posedge clk);
            #1;
            instr_ack = 1'b0;
            faulted   = 1'b1;
            chk("fault_set", fetch_fault, 1);
            chk("fault_instr_valid", instr_valid, 0);
            chk("fault_pc", pc, m_pc);
            imem_req_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                chk("fault_no_req", imem_req_valid, 0);
            end
            imem_req_ready = 1'b0;
            return;
        end
`else
        nxt[1:0] = 2'b00;
`endif
        exp_addr_q.push_back(nxt);
        @(posedge clk);
        #1;
        instr_ack = 1'b0;
        m_pc = nxt;
        chk("retire_valid_low", instr_valid, 0);
        chk("retire_back_to_req", imem_req_valid, 1);
        chk("retire_no_fault", fetch_fault, 0);
    endtask

    initial begin
        logic f;
        logic [31:0] imm;
        m_pc    = 32'h0;
        m_instr = NOP_INSTR;

        // Reset values and sequential zero-wait fetch: 0,4,8,C at 3 cycles each
        do_reset();
        for (int i = 0; i < 4; i++) do_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, f);
        chk("seq_pc", pc, 32'h10);

        // Request held off by imem_req_ready for 4 cycles
        do_instr(4, 0, 0, 1'b0, 32'h0, 1'b0, f);
        chk("stall_pc", pc, 32'h14);

        // Branch to 0x20, then backwards by -8 to 0x18
        do_instr(0, 1, 0, 1'b1, 32'h0000_000C, 1'b0, f);
        chk("branch_fwd", imem_addr, 32'h20);
        do_instr(0, 0, 1, 1'b1, 32'hFFFF_FFF8, 1'b0, f);
        chk("branch_back", imem_addr, 32'h18);

        // Spurious responses in S_REQ/S_HOLD and acks in S_WAIT are ignored
        do_instr(2, 2, 2, 1'b0, 32'h0, 1'b1, f);
        do_instr(3, 1, 3, 1'b1, 32'h40, 1'b1, f);

        // Reset during S_WAIT abandons the transaction
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr_valid", instr_valid, 0);
        chk("midrst_instr", instr, NOP_INSTR);
        do_reset();
        do_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, f);
        chk("midrst_restart", pc, 32'h4);

        // Misaligned branch target from 0x10 with offset 6
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, f);
        chk("pre_misalign_pc", pc, 32'h10);
        do_instr(0, 0, 0, 1'b1, 32'h6, 1'b0, f);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_trapped", f, 1);
        do_reset();
`else
        chk("misalign_forced", imem_addr, 32'h14);
`endif

        // Wrap-around below zero and back
        imm = 32'h0 - m_pc - 32'd4;
        do_instr(0, 0, 0, 1'b1, imm, 1'b0, f);
        chk("wrap_low", pc, 32'hFFFF_FFFC);
        do_instr(1, 0, 0, 1'b0, 32'h0, 1'b0, f);
        chk("wrap_zero", pc, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            imm = 32'($urandom_range(0, 255)) * 32'd4 - 32'd512;
`else
            imm = 32'($urandom_range(0, 1023)) - 32'd512;
`endif
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm,
                     1'($urandom_range(0, 1)), f);
            if (f) do_reset();
        end

        // Final pending fetch handshake drains the scoreboard
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("addr_q_drained", 32'(exp_addr_q.size()), 0);
        chk("instr_q_drained", 32'(exp_instr_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
